// File: rtl/param_mem_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Holds the init/run state encoding and a ceiling-log2 helper for parameter math.
package param_mem_pkg;

  typedef enum logic {
    MEM_INIT,
    MEM_RUN
  } mem_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Init/run sequencer for param_data_memory: sweeps every word index once after reset,
// then raises ready and stays in MEM_RUN until the next reset.
module mem_init_ctrl
  import param_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  output logic             ready,
  output logic             init_we,
  output logic [IDX_W-1:0] init_idx
);

  mem_state_t       state;
  logic [IDX_W-1:0] ptr;

  // ready rises on the same edge that writes the last word, so it is seen one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= MEM_INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else if (state == MEM_INIT) begin
      if (ptr == IDX_W'(DEPTH - 1)) begin
        state <= MEM_RUN;
        ready <= 1'b1;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign init_we  = (state == MEM_INIT);
  assign init_idx = ptr;

endmodule

// File: rtl/param_data_memory.sv
// Byte-addressed word memory with per-byte enables, registered read, init sweep and address checking.
// Define MEM_PARITY_EN to add per-byte even parity storage and the ParityError output.
module param_data_memory
  import param_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  input  logic [DATA_WIDTH-1:0]   writeData,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    Ready,
  output logic                    AddrError
`ifdef MEM_PARITY_EN
  ,
  output logic                    ParityError
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = clog2(BYTES);
  localparam int IDX_W = clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [IDX_W-1:0]      init_idx;
  logic [ADDR_WIDTH-1:0] word_full;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned;
  logic                  in_range;
  logic                  legal;
  logic                  accept;

  mem_init_ctrl #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_init_ctrl (
    .clock   (clock),
    .reset   (reset),
    .ready   (Ready),
    .init_we (init_we),
    .init_idx(init_idx)
  );

  // Range is judged on the full word index before truncation, so high addresses never alias
  assign word_full  = Address >> LSB;
  assign misaligned = |(Address & LSB_MASK);
  assign in_range   = ({1'b0, word_full} < DEPTH_W);
  assign legal      = !misaligned && in_range;
  assign idx        = word_full[IDX_W-1:0];
  assign accept     = Ready && (MemRead || MemWrite);

`ifdef MEM_PARITY_EN
  logic [BYTES-1:0] parity_mem [DEPTH];

  function automatic logic [BYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] word);
    logic [BYTES-1:0] p;
    for (int b = 0; b < BYTES; b++) p[b] = ^word[8*b +: 8];
    return p;
  endfunction
`endif

  // The init sweep owns the write port until Ready, so user writes cannot race it
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_idx] <= INIT_VALUE;
`ifdef MEM_PARITY_EN
      parity_mem[init_idx] <= byte_parity(INIT_VALUE);
`endif
    end else if (accept && MemWrite && legal) begin
      for (int b = 0; b < BYTES; b++) begin
        if (ByteEnable[b]) begin
          mem[idx][8*b +: 8] <= writeData[8*b +: 8];
`ifdef MEM_PARITY_EN
          parity_mem[idx][b] <= ^writeData[8*b +: 8];
`endif
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands, giving read-before-write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
`ifdef MEM_PARITY_EN
      ParityError <= 1'b0;
`endif
    end else begin
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
`ifdef MEM_PARITY_EN
      ParityError <= 1'b0;
`endif
      if (accept) begin
        if (!legal) begin
          AddrError <= 1'b1;
        end else if (MemRead) begin
          ReadData  <= mem[idx];
          ReadValid <= 1'b1;
`ifdef MEM_PARITY_EN
          ParityError <= |(parity_mem[idx] ^ byte_parity(mem[idx]));
`endif
        end
      end
    end
  end

endmodule
